aes_subbytes_seq: RTL

//  Sequential AES SubBytes stage. Accepts a 128-bit AES state over a valid/ready handshake,

---
 rtl/aes_subbytes_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/aes_subbytes_seq.sv
// -----------------------------------------------------------------------------
// aes_subbytes_seq
//   Sequential AES SubBytes stage for the iterative round datapath
//   (AddRoundKey -> SubBytes -> ShiftRows). A 128-bit state is accepted,
//   substituted BPC bytes per cycle through BPC combinational S-boxes over
//   16/BPC cycles, then held for the downstream consumer.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   upstream state valid
//     in_ready   block can accept a state (IDLE only)
//     in_data    input state, byte k = in_data[127-8k -: 8] (FIPS-197 order)
//     out_valid  substituted state valid (DONE only)
//     out_ready  downstream accepts
//     out_data   substituted state, same byte order as in_data
//     busy       high in BUSY or DONE
//
//   Parameter
//     BPC        bytes substituted per cycle: 1, 2, 4, 8 or 16
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// aes_sbox
//   Purely combinational FIPS-197 forward S-box.
//     a_i  input byte
//     y_o  substituted byte
// -----------------------------------------------------------------------------
module aes_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);

   // Row r of the table is S(r0)..S(rf); entry 0 sits in the top byte.
   localparam logic [2047:0] TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign y_o = TBL[11'd2047 - {a_i, 3'b000} -: 8];

endmodule

module aes_subbytes_seq #(
   parameter int BPC = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int NGRP = 16 / BPC;
   localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam logic [GW-1:0] GRP_LAST = GW'(NGRP - 1);

   generate
      if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
         $error("aes_subbytes_seq: BPC must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   grp_q, grp_d;
   logic [127:0]    work_q, work_d;

   // Byte views of the work register: FIPS byte k lives at index 15-k.
   logic [15:0][7:0]     work_b;
   logic [15:0][7:0]     sub_b;
   logic [BPC-1:0][3:0]  lidx;
   logic [BPC-1:0][7:0]  sb_out;

   assign work_b = work_q;

   // Lane j of group g handles FIPS byte g*BPC + j.
   always_comb begin
      lidx = '0;
      for (int j = 0; j < BPC; j++) begin
         lidx[j] = 4'(15 - (int'(grp_q) * BPC + j));
      end
   end

   generate
      for (genvar j = 0; j < BPC; j++) begin : g_lane
         aes_sbox u_sbox (
            .a_i (work_b[lidx[j]]),
            .y_o (sb_out[j])
         );
      end
   endgenerate

   // Work register with the current group's bytes replaced.
   always_comb begin
      sub_b = work_b;
      for (int j = 0; j < BPC; j++) begin
         sub_b[lidx[j]] = sb_out[j];
      end
   end

   always_comb begin
      state_d = state_q;
      grp_d   = grp_q;
      work_d  = work_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               work_d  = in_data;
               grp_d   = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            work_d = sub_b;
            if (grp_q == GRP_LAST) begin
               grp_d   = '0;
               state_d = S_DONE;
            end else begin
               grp_d = grp_q + GW'(1);
            end
         end
         S_DONE: begin
            // Returning to IDLE first keeps in_ready a pure state decode.
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grp_q   <= '0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         grp_q   <= grp_d;
         work_q  <= work_d;
      end
   end

   // Handshake outputs depend on state only; out_data is only meaningful
   // while out_valid is high since it tracks the work register in BUSY.
   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign out_data  = work_q;

endmodule
